// File: rtl/asip_data_mem.sv
// ---------------------------------------------------------------------------
// asip_data_mem
// Data memory for a small ASIP: 24-bit words, combinational read port for
// the processor, a synchronous store port, and a byte-serial preload engine
// that assembles MSB-first bytes into words and streams them into memory
// while holding the processor off.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-low reset (release synchronized)
//   addr       in  16   processor word address
//   wrData     in  24   processor store data
//   memWrite   in   1   processor store strobe
//   rdData     out 24   mem[addr] when addr < DEPTH, else 0 (combinational)
//   ldStart    in   1   pulse: open a preload session
//   ldValid    in   1   loader byte valid
//   ldByte     in   8   loader byte
//   ldReady    out  1   loader byte may be accepted
//   ldDone     in   1   pulse: close the preload session
//   cpuHold    out  1   processor stall while a session is open
//   wordCount  out 16   words committed in the current/last session
//   errFlag    out  1   sticky out-of-range store / aborted-word flag
// ---------------------------------------------------------------------------
module asip_data_mem #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [23:0] wrData,
    input  logic        memWrite,
    output logic [23:0] rdData,
    input  logic        ldStart,
    input  logic        ldValid,
    input  logic [7:0]  ldByte,
    output logic        ldReady,
    input  logic        ldDone,
    output logic        cpuHold,
    output logic [15:0] wordCount,
    output logic        errFlag
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_COMMIT
    } state_t;

    logic [23:0]   r_mem [DEPTH];
    logic [1:0]    r_rst_sync;
    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [23:0]   r_word;
    logic [15:0]   r_word_cnt;
    logic          r_err;
    logic          r_ld_ready;
    logic          r_cpu_hold;

    logic          w_rst_n;
    logic          w_in_range;
    logic [AW-1:0] w_addr_idx;
    logic          w_cpu_we;
    logic          w_cpu_oob;
    logic          w_commit;
    logic          w_hs;

    // Assertion is immediate (async clear), release is delayed two edges so
    // the FSM always leaves reset on a clean clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n    = r_rst_sync[1];
    assign w_in_range = ({16'h0000, addr} < 32'(DEPTH));
    assign w_addr_idx = addr[AW-1:0];

    // Processor stores are only honoured in IDLE; during a session the
    // processor is stalled and its strobe is ignored.
    assign w_cpu_we  = w_rst_n && memWrite && (r_state == S_IDLE) && w_in_range;
    assign w_cpu_oob = memWrite && (r_state == S_IDLE) && !w_in_range;
    assign w_commit  = (r_state == S_COMMIT);
    assign w_hs      = ldValid && r_ld_ready;

    assign rdData    = w_in_range ? r_mem[w_addr_idx] : 24'h000000;
    assign ldReady   = r_ld_ready;
    assign cpuHold   = r_cpu_hold;
    assign wordCount = r_word_cnt;
    assign errFlag   = r_err;

    // Memory array: never reset. The loader commit wins over a CPU store,
    // although the CPU path is already gated off outside IDLE.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_ptr] <= r_word;
        end else if (w_cpu_we) begin
            r_mem[w_addr_idx] <= wrData;
        end
    end

    // Preload FSM with registered handshake/stall outputs.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_word     <= 24'h000000;
            r_word_cnt <= 16'h0000;
            r_err      <= 1'b0;
            r_ld_ready <= 1'b0;
            r_cpu_hold <= 1'b0;
        end else begin
            if (w_cpu_oob) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (ldStart) begin
                        r_state    <= S_B0;
                        r_ptr      <= '0;
                        r_word     <= 24'h000000;
                        r_word_cnt <= 16'h0000;
                        r_ld_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                    end
                end
                S_B0: begin
                    // ldDone beats a simultaneous byte.
                    if (ldDone) begin
                        r_state    <= S_IDLE;
                        r_ld_ready <= 1'b0;
                        r_cpu_hold <= 1'b0;
                    end else if (w_hs) begin
                        r_word  <= {ldByte, 16'h0000};
                        r_state <= S_B1;
                    end
                end
                S_B1: begin
                    if (ldDone) begin
                        r_state    <= S_IDLE;
                        r_word     <= 24'h000000;
                        r_err      <= 1'b1;
                        r_ld_ready <= 1'b0;
                        r_cpu_hold <= 1'b0;
                    end else if (w_hs) begin
                        r_word[15:8] <= ldByte;
                        r_state      <= S_B2;
                    end
                end
                S_B2: begin
                    if (ldDone) begin
                        r_state    <= S_IDLE;
                        r_word     <= 24'h000000;
                        r_err      <= 1'b1;
                        r_ld_ready <= 1'b0;
                        r_cpu_hold <= 1'b0;
                    end else if (w_hs) begin
                        r_word[7:0] <= ldByte;
                        r_state     <= S_COMMIT;
                        r_ld_ready  <= 1'b0;
                    end
                end
                S_COMMIT: begin
                    // The memory write happens this edge regardless of ldDone.
                    r_ptr <= r_ptr + AW'(1);
                    if (r_word_cnt != 16'hFFFF) begin
                        r_word_cnt <= r_word_cnt + 16'd1;
                    end
                    if (ldDone) begin
                        r_state    <= S_IDLE;
                        r_ld_ready <= 1'b0;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_state    <= S_B0;
                        r_ld_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_ld_ready <= 1'b0;
                    r_cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule
